// File: rtl/serial_rx.sv
`timescale 1ns/1ps
// serial_rx: 16x-oversampling UART receiver (idle high, 8N1, LSB first) driven by a
// phase-accumulator baud tick; strobes valid on a good frame, framingError on a bad stop bit.
module serial_rx #(
  parameter int          ACC_W = 32,
  parameter int unsigned INCR  = 64000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxIn,
  output logic [7:0] data,
  output logic       valid,
  output logic       framingError,
  output logic       busy,
  output logic [2:0] dbg_state
);

  // Output handshake: valid and framingError are single-clk strobes with no ready/backpressure;
  // data is a holding register that keeps the last good byte until the next good frame.
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

  localparam logic [ACC_W-1:0] INCR_W = ACC_W'(INCR);

  state_t           state, state_nx;
  logic             sync1, rx_s, rx_prev;
  logic [1:0]       fill;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic             tick;
  logic [3:0]       tcnt;
  logic [2:0]       bcnt;
  logic [7:0]       shift;
  logic             clr_acc, clr_tcnt, clr_bcnt, shift_en, valid_nx, ferr_nx;

  assign acc_sum   = {1'b0, acc} + {1'b0, INCR_W};
  assign tick      = acc_sum[ACC_W];
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1        <= 1'b1;
      rx_s         <= 1'b1;
      rx_prev      <= 1'b0;
      fill         <= 2'b00;
      state        <= IDLE;
      acc          <= '0;
      tcnt         <= 4'd0;
      bcnt         <= 3'd0;
      shift        <= 8'h00;
      data         <= 8'h00;
      valid        <= 1'b0;
      framingError <= 1'b0;
    end else begin
      sync1 <= rxIn;
      rx_s  <= sync1;
      fill  <= {fill[0], 1'b1};
      // rx_prev only reports a high once the synchroniser holds real line samples, so a line
      // that is low at reset release cannot look like a falling edge.
      rx_prev <= fill[1] ? rx_s : 1'b0;
      state   <= state_nx;
      acc     <= clr_acc ? '0 : acc_sum[ACC_W-1:0];
      if (clr_tcnt)  tcnt <= 4'd0;
      else if (tick) tcnt <= tcnt + 4'd1;
      if (clr_bcnt)      bcnt <= 3'd0;
      else if (shift_en) bcnt <= bcnt + 3'd1;
      if (shift_en) shift <= {rx_s, shift[7:1]};
      if (valid_nx) data <= shift;
      valid        <= valid_nx;
      framingError <= ferr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    clr_acc  = 1'b0;
    clr_tcnt = 1'b0;
    clr_bcnt = 1'b0;
    shift_en = 1'b0;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s && rx_prev) begin
          clr_acc  = 1'b1;
          clr_tcnt = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        if (tick && tcnt == 4'd7) begin
          if (rx_s) begin
            state_nx = IDLE;
          end else begin
            clr_tcnt = 1'b1;
            clr_bcnt = 1'b1;
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        if (tick && tcnt == 4'd15) begin
          shift_en = 1'b1;
          if (bcnt == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        // Returning to IDLE mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (tick && tcnt == 4'd15) begin
          if (rx_s) begin
            valid_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = WAITHI;
          end
        end
      end
      WAITHI: begin
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_rx.sv
`timescale 1ns/1ps
// tb_serial_rx: directed frames into serial_rx with a queue scoreboard; a monitor pops one
// expected {is_error, data} entry for every valid or framingError strobe.
module tb_serial_rx;

  // INCR = 2^28 gives one tick every 16 clks, so one bit = 256 clks = 5120 ns at 50 MHz.
  localparam int unsigned INCR_TB = 32'h1000_0000;
  localparam real         NOM     = 5120.0;

  logic       clk;
  logic       reset;
  logic       rxIn;
  logic [7:0] data;
  logic       valid;
  logic       framingError;
  logic       busy;
  logic [2:0] dbg_state;

  logic [8:0] exp_q[$];
  logic [7:0] last_good;
  int         n_checks;
  int         n_errors;

  serial_rx #(.ACC_W(32), .INCR(INCR_TB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rxIn         (rxIn),
    .data         (data),
    .valid        (valid),
    .framingError (framingError),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // driver tasks
  task automatic send_frame(input logic [7:0] b, input real bit_ns, input logic stop_val,
                            input int stop_bits);
    rxIn = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxIn = b[i];
      #(bit_ns);
    end
    rxIn = stop_val;
    #(bit_ns * stop_bits);
  endtask

  task automatic push_good(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
    last_good = b;
  endtask

  task automatic idle_clks(input int n);
    rxIn = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_busy_low(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [8:0] exp_item;
    if (!reset && (valid || framingError)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: valid=%b framingError=%b data=%h, expected no strobe",
                 valid, framingError, data);
      end else begin
        exp_item = exp_q.pop_front();
        check("strobe_frame", {22'd0, framingError, valid, data},
              {22'd0, exp_item[8], ~exp_item[8], exp_item[7:0]});
      end
    end
  end

  // stimulus
  initial begin
    logic [7:0] c3;
    c3        = 8'hC3;
    n_checks  = 0;
    n_errors  = 0;
    last_good = 8'h00;
    reset     = 1'b1;
    rxIn      = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_data", {24'd0, data}, 0);
    check("reset_valid", {31'd0, valid}, 0);
    check("reset_ferr", {31'd0, framingError}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_state", {29'd0, dbg_state}, 0);
    idle_clks(40);

    // 1: single good frame
    push_good(8'h35);
    send_frame(8'h35, NOM, 1'b1, 1);
    wait_drain("t1_drain", 300);
    wait_busy_low("t1_busy_low", 50);
    idle_clks(40);

    // 2: back-to-back frames, second start edge right after the stop bit
    push_good(8'h61);
    push_good(8'hA5);
    send_frame(8'h61, NOM, 1'b1, 1);
    send_frame(8'hA5, NOM, 1'b1, 1);
    wait_drain("t2_drain", 300);
    idle_clks(40);

    // 3: 10-clk glitch -> false start, no strobe
    rxIn = 1'b0;
    repeat (10) @(posedge clk);
    rxIn = 1'b1;
    @(negedge clk);
    check("t3_busy_seen", {31'd0, busy}, 1);
    wait_busy_low("t3_busy_low", 150);
    idle_clks(300);

    // 4: stop bit held low for two bit times -> framingError, data keeps previous byte
    exp_q.push_back({1'b1, last_good});
    send_frame(8'h00, NOM, 1'b0, 2);
    wait_drain("t4_drain", 10);
    @(negedge clk);
    check("t4_busy_held", {31'd0, busy}, 1);
    check("t4_data_kept", {24'd0, data}, {24'd0, last_good});
    rxIn = 1'b1;
    wait_busy_low("t4_busy_low", 10);
    idle_clks(300);

    // 5: reset during data bit 4 of 8'hC3, then a full 8'hC3 frame
    rxIn = 1'b0;
    #(NOM);
    for (int i = 0; i < 4; i++) begin
      rxIn = c3[i];
      #(NOM);
    end
    rxIn = c3[4];
    #(NOM / 2);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5_reset_data", {24'd0, data}, 0);
    check("t5_reset_valid", {31'd0, valid}, 0);
    check("t5_reset_busy", {31'd0, busy}, 0);
    check("t5_reset_state", {29'd0, dbg_state}, 0);
    last_good = 8'h00;
    @(posedge clk);
    #1 reset = 1'b0;
    #(NOM / 2);
    for (int i = 5; i < 8; i++) begin
      rxIn = c3[i];
      #(NOM);
    end
    rxIn = 1'b1;
    #(NOM);
    check("t5_no_restart", {31'd0, busy}, 0);
    idle_clks(100);
    push_good(8'hC3);
    send_frame(8'hC3, NOM, 1'b1, 1);
    wait_drain("t5_drain", 300);
    idle_clks(100);

    // 6: sender bit period +2% and -2%
    push_good(8'h55);
    send_frame(8'h55, NOM * 1.02, 1'b1, 1);
    wait_drain("t6_slow_drain", 300);
    idle_clks(100);
    push_good(8'h55);
    send_frame(8'h55, NOM * 0.98, 1'b1, 1);
    wait_drain("t6_fast_drain", 300);
    idle_clks(100);
    check("final_data", {24'd0, data}, 32'h55);

    // final report
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
